// File: rtl/floo_link_delay.sv
// Elastic, order-preserving link stage: each accepted flit waits at least Latency
// cycles before it is offered downstream, with up to Depth flits in flight.
module floo_link_delay #(
  parameter type         flit_t   = logic [63:0],
  parameter int unsigned Latency  = 4,
  parameter int unsigned Depth    = 8,
  parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  output logic                ready_o,
  input  flit_t               data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output flit_t               data_o,
  output logic [CntWidth-1:0] occupancy_o
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid_o/data_o hold until popped, ready_o never depends on ready_i.

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned AgeW = $clog2(Latency + 1);

  localparam logic [AgeW-1:0]     AgeMax  = AgeW'(Latency);
  localparam logic [PtrW-1:0]     PtrLast = PtrW'(Depth - 1);
  localparam logic [CntWidth-1:0] CntFull = CntWidth'(Depth);

  flit_t                mem_q [Depth];
  logic [AgeW-1:0]      age_q [Depth];
  logic [PtrW-1:0]      wptr_q;
  logic [PtrW-1:0]      rptr_q;
  logic [CntWidth-1:0]  count_q;
  logic                 push;
  logic                 pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  assign ready_o     = (count_q != CntFull);
  assign valid_o     = (count_q != '0) && (age_q[rptr_q] == AgeMax);
  assign data_o      = valid_o ? mem_q[rptr_q] : '0;
  assign push        = valid_i && ready_o;
  assign pop         = valid_o && ready_i;
  assign occupancy_o = count_q;

  // Age 0 marks a free slot; a push stores age 1 so that the push edge itself
  // counts toward the delay and Latency=1 behaves as a plain register stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      if (push) wptr_q <= next_ptr(wptr_q);
      if (pop)  rptr_q <= next_ptr(rptr_q);
      if (push && !pop) begin
        count_q <= count_q + CntWidth'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CntWidth'(1);
      end
      for (int unsigned i = 0; i < Depth; i++) begin
        if (push && (wptr_q == PtrW'(i))) begin
          age_q[i] <= AgeW'(1);
        end else if (pop && (rptr_q == PtrW'(i))) begin
          age_q[i] <= '0;
        end else if ((age_q[i] != '0) && (age_q[i] != AgeMax)) begin
          age_q[i] <= age_q[i] + AgeW'(1);
        end
      end
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the ages.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= data_i;
  end

  if ((Latency < 1) || (Latency > 255)) begin : g_bad_latency
    $error("floo_link_delay: Latency must be in 1..255");
  end
  if (Depth < 1) begin : g_bad_depth
    $error("floo_link_delay: Depth must be at least 1");
  end

  a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CntFull);

  a_out_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i) |=> (valid_o && $stable(data_o)));

endmodule
